// File: rtl/pc_gen.sv
// Program counter generator for the fetch stage. It resolves the next fetch address
// from trap, redirect and stall inputs, return-address-stack prediction and the sequential increment.
module pc_gen #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_0040),
  parameter int unsigned          INC          = 4,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                trap,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                push_ras,
  input  logic                pop_ras,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                pc_valid,
  output logic                misaligned,
  output logic                ras_empty,
  output logic                ras_full
);

  localparam int unsigned       PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] INC_PC   = PC_WIDTH'(INC);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INC - 1);

  typedef enum logic [2:0] {
    ACT_TRAP,
    ACT_REDIRECT,
    ACT_HOLD,
    ACT_POP,
    ACT_SWAP,
    ACT_PUSH,
    ACT_SEQ
  } act_t;

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr;
  logic [CNT_W-1:0]    ras_cnt;

  act_t                act;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PTR_W-1:0]    ptr_inc;
  logic [PTR_W-1:0]    ptr_dec;

  assign pc_seq     = pc_out + INC_PC;
  assign ras_empty  = (ras_cnt == '0);
  assign ras_full   = (ras_cnt == CNT_FULL);
  assign misaligned = |(pc_out & ALIGN_MASK);

  // The stack is a circular buffer, so a push while full overwrites the oldest entry.
  assign ptr_inc = (ras_ptr == PTR_LAST) ? '0 : ras_ptr + PTR_W'(1);
  assign ptr_dec = (ras_ptr == '0) ? PTR_LAST : ras_ptr - PTR_W'(1);

  always_comb begin
    act = ACT_SEQ;
    if (trap)
      act = ACT_TRAP;
    else if (redirect_valid)
      act = ACT_REDIRECT;
    else if (stall)
      act = ACT_HOLD;
    else if (pop_ras && !ras_empty)
      act = push_ras ? ACT_SWAP : ACT_POP;
    else if (push_ras)
      act = ACT_PUSH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out   <= RESET_VECTOR;
      pc_valid <= 1'b0;
      ras_cnt  <= '0;
      ras_ptr  <= '0;
    end else begin
      pc_valid <= 1'b1;
      unique case (act)
        ACT_TRAP: begin
          pc_out  <= TRAP_VECTOR;
          ras_cnt <= '0;
        end
        ACT_REDIRECT: pc_out <= redirect_pc;
        ACT_HOLD:     ;
        ACT_POP: begin
          pc_out  <= ras_mem[ras_ptr];
          ras_ptr <= ptr_dec;
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
        ACT_SWAP: begin
          pc_out           <= ras_mem[ras_ptr];
          ras_mem[ras_ptr] <= pc_seq;
        end
        ACT_PUSH: begin
          pc_out           <= pc_seq;
          ras_mem[ptr_inc] <= pc_seq;
          ras_ptr          <= ptr_inc;
          if (!ras_full)
            ras_cnt <= ras_cnt + CNT_W'(1);
        end
        default: pc_out <= pc_seq;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen. It uses a default 32-bit instance and an 8-bit
// instance for the wrap and alignment cases.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        reset, stall, trap, redirect_valid, push_ras, pop_ras;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic        pc_valid, misaligned, ras_empty, ras_full;

  logic        b_reset, b_redirect_valid;
  logic [7:0]  b_redirect_pc;
  logic [7:0]  b_pc_out;
  logic        b_pc_valid, b_misaligned, b_ras_empty, b_ras_full;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .trap(trap),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .push_ras(push_ras), .pop_ras(pop_ras),
    .pc_out(pc_out), .pc_valid(pc_valid), .misaligned(misaligned),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  pc_gen #(.PC_WIDTH(8)) dut8 (
    .clk(clk), .reset(b_reset), .stall(1'b0), .trap(1'b0),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .push_ras(1'b0), .pop_ras(1'b0),
    .pc_out(b_pc_out), .pc_valid(b_pc_valid), .misaligned(b_misaligned),
    .ras_empty(b_ras_empty), .ras_full(b_ras_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; trap = 0; redirect_valid = 0; push_ras = 0; pop_ras = 0;
  endtask

  task automatic jump(input logic [31:0] target);
    redirect_valid = 1; redirect_pc = target;
    tick();
    redirect_valid = 0;
  endtask

  task automatic push_at(input logic [31:0] target);
    jump(target);
    push_ras = 1;
    tick();
    push_ras = 0;
  endtask

  initial begin
    reset = 1; redirect_pc = '0; idle();
    b_reset = 1; b_redirect_valid = 0; b_redirect_pc = '0;

    tick(); tick();
    check("rst_pc", pc_out, 64'h0);
    check("rst_valid", pc_valid, 0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);

    reset = 0;
    tick(); check("seq_4", pc_out, 64'h4); check("valid_first", pc_valid, 1);
    tick(); check("seq_8", pc_out, 64'h8);
    tick(); check("seq_c", pc_out, 64'hC); check("aligned", misaligned, 0);
    tick(); check("seq_10", pc_out, 64'h10);

    stall = 1; redirect_valid = 1; redirect_pc = 32'h200;
    tick(); check("redir_over_stall", pc_out, 64'h200);
    redirect_valid = 0;
    tick(); check("stall_hold", pc_out, 64'h200);
    stall = 0;

    push_at(32'h100);
    push_at(32'h200);
    push_at(32'h300);
    check("ras_not_full_3", ras_full, 0);
    push_at(32'h400);
    check("ras_full_4", ras_full, 1);
    push_at(32'h500);
    check("ras_full_5", ras_full, 1);
    check("pc_after_push", pc_out, 64'h504);

    pop_ras = 1;
    tick(); check("pop1", pc_out, 64'h504);
    check("full_after_pop", ras_full, 0);
    tick(); check("pop2", pc_out, 64'h404);
    tick(); check("pop3", pc_out, 64'h304);
    tick(); check("pop4", pc_out, 64'h204);
    check("empty_after_pops", ras_empty, 1);
    tick(); check("pop_empty_seq", pc_out, 64'h208);
    check("still_empty", ras_empty, 1);
    pop_ras = 0;

    push_ras = 1;
    tick(); tick();
    push_ras = 0;
    check("two_pushed_pc", pc_out, 64'h210);
    check("two_pushed_nonempty", ras_empty, 0);
    trap = 1; redirect_valid = 1; redirect_pc = 32'h900; pop_ras = 1; stall = 1;
    tick(); check("trap_pc", pc_out, 64'h40);
    check("trap_clears_ras", ras_empty, 1);
    idle(); pop_ras = 1;
    tick(); check("pop_after_trap", pc_out, 64'h44);
    pop_ras = 0;

    push_at(32'h20);
    check("push_top_pc", pc_out, 64'h24);
    jump(32'h80);
    check("redir_keeps_ras", ras_empty, 0);
    push_ras = 1; pop_ras = 1;
    tick(); check("swap_pc", pc_out, 64'h24);
    check("swap_nonempty", ras_empty, 0);
    check("swap_not_full", ras_full, 0);
    push_ras = 0;
    tick(); check("swap_new_top", pc_out, 64'h84);
    check("swap_then_empty", ras_empty, 1);
    pop_ras = 0;

    stall = 1; push_ras = 1;
    tick(); check("stall_ignores_push_pc", pc_out, 64'h84);
    check("stall_ignores_push_ras", ras_empty, 1);
    idle();

    jump(32'h86);
    check("misaligned_32", misaligned, 1);
    push_ras = 1;
    tick(); check("push_misaligned", pc_out, 64'h8A);
    push_ras = 0;
    reset = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h300;
    tick();
    check("midrst_pc", pc_out, 64'h0);
    check("midrst_valid", pc_valid, 0);
    check("midrst_empty", ras_empty, 1);
    reset = 0; idle();
    tick(); check("midrst_release", pc_out, 64'h4);

    tick();
    check("w8_rst", b_pc_out, 64'h0);
    b_reset = 0; b_redirect_valid = 1; b_redirect_pc = 8'hFC;
    tick(); check("w8_fc", b_pc_out, 64'hFC);
    b_redirect_valid = 0;
    tick(); check("w8_wrap", b_pc_out, 64'h00);
    check("w8_aligned", b_misaligned, 0);
    b_redirect_valid = 1; b_redirect_pc = 8'h06;
    tick(); check("w8_mis", b_misaligned, 1);
    check("w8_pc_06", b_pc_out, 64'h06);
    b_redirect_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, program counter width in bits (legal range 8..64).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, value loaded into pc_out on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0040, value loaded on trap.
REQ-004 SHALL have parameter INC, default 4, sequential increment (legal values 1, 2, 4, 8).
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (legal range 2..16).
REQ-006 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port stall  in  1  hold current PC.
REQ-009 SHALL have port trap  in  1  jump to TRAP_VECTOR.
REQ-010 SHALL have port redirect_valid  in  1  resolved branch/jump redirect.
REQ-011 SHALL have port redirect_pc  in  PC_WIDTH  redirect target.
REQ-012 SHALL have port push_ras  in  1  current fetch is a call; push return address.
REQ-013 SHALL have port pop_ras  in  1  current fetch is a return; predict from RAS top.
REQ-014 SHALL have port pc_out  out  PC_WIDTH  current fetch address (registered).
REQ-015 SHALL have port pc_valid  out  1  pc_out holds a meaningful address.
REQ-016 SHALL have port misaligned  out  1  pc_out not aligned to INC.
REQ-017 SHALL have ports ras_empty, ras_full  out  1 each  RAS occupancy flags.

Function
REQ-018 SHALL resolve next PC each rising edge by strict priority: reset > trap > redirect_valid > stall > pop_ras (RAS non-empty) > sequential.
REQ-019 SHALL load TRAP_VECTOR on trap regardless of stall, redirect_valid, push_ras or pop_ras.
REQ-020 SHALL load redirect_pc on redirect_valid (trap low) regardless of stall; redirect_pc is not aligned or checked.
REQ-021 SHALL hold pc_out and all RAS state when stall is high and neither trap nor redirect_valid is high; push_ras/pop_ras ignored that cycle.
REQ-022 SHALL, in the sequential case, load pc_out + INC modulo 2^PC_WIDTH (wrap from all-ones region to low addresses, no flag).
REQ-023 SHALL, on pop_ras with RAS non-empty (no higher-priority event), load RAS top into pc_out and decrement occupancy.
REQ-024 SHALL treat pop_ras with RAS empty as sequential; occupancy stays 0.
REQ-025 SHALL, on push_ras (no higher-priority event, no pop), write pc_out + INC as new top and advance sequentially.
REQ-026 SHALL, when RAS full and push occurs, overwrite the oldest entry (circular), occupancy saturating at RAS_DEPTH.
REQ-027 SHALL, on simultaneous push_ras and pop_ras with RAS non-empty, load old top into pc_out and replace top with pc_out + INC, occupancy unchanged; with RAS empty, behave as push only.
REQ-028 SHALL clear RAS occupancy to 0 on trap; redirect_valid SHALL NOT modify RAS contents or occupancy.
REQ-029 SHALL drive ras_empty = (occupancy == 0) and ras_full = (occupancy == RAS_DEPTH), combinationally from registered state.
REQ-030 SHALL drive misaligned = OR of pc_out low log2(INC) bits; constant 0 when INC == 1.
REQ-031 SHALL set pc_valid to 1 on the first rising edge with reset low and keep it 1 until next reset.

Reset
REQ-032 SHALL, on a rising edge with reset high, set pc_out = RESET_VECTOR, pc_valid = 0, RAS occupancy = 0 (ras_empty = 1, ras_full = 0), overriding all other inputs.
REQ-033 SHALL allow reset mid-operation (during stall, redirect or RAS activity) with identical result; RAS entry contents need not be cleared.

Verification
REQ-034 SHALL cover: reset 2 cycles then release, no other inputs -> pc_out 0x0, 0x4, 0x8, 0xC on successive edges; pc_valid 0 then 1 from first post-reset edge.
REQ-035 SHALL cover: pc_out=0x10, stall=1 and redirect_valid=1 redirect_pc=0x200 same cycle -> pc_out=0x200; next cycle stall=1 alone -> pc_out stays 0x200.
REQ-036 SHALL cover: push_ras at pc 0x100, 0x200, 0x300, 0x400, 0x500 (RAS_DEPTH=4) -> ras_full after 4th; 4 pops return 0x504, 0x404, 0x304, 0x204; 5th pop -> sequential, ras_empty=1.
REQ-037 SHALL cover: trap=1 with redirect_valid=1, pop_ras=1, RAS holding 2 entries -> pc_out=0x40, ras_empty=1.
REQ-038 SHALL cover: PC_WIDTH=8, pc_out=0xFC, sequential -> pc_out=0x00; redirect_pc=0x06 -> misaligned=1.
REQ-039 SHALL cover: push_ras and pop_ras together at pc 0x80 with top 0x24 -> pc_out=0x24, top=0x84, occupancy unchanged.
